// File: rtl/pico_exec_ctrl_if.sv
// Signal bundle between the picoMIPS datapath/decoder and the execution sequencer.
// The sequencer takes the slave view; the system side takes the master view.
interface pico_exec_ctrl_if #(
  parameter int unsigned Psize = 6,
  parameter int unsigned CNTW  = 16
);
  logic             run_sw;
  logic             step_btn;
  logic             bflag_raw;
  logic [Psize-1:0] pc_value;
  logic             wait_req;
  logic             halt_req;
  logic [Psize-1:0] bkpt_addr;
  logic             bkpt_on;
  logic             cpu_en;
  logic [2:0]       state_o;
  logic             halted;
  logic             bkpt_hit;
  logic [CNTW-1:0]  instr_cnt;

  modport master (
    output run_sw, step_btn, bflag_raw, pc_value, wait_req, halt_req, bkpt_addr, bkpt_on,
    input  cpu_en, state_o, halted, bkpt_hit, instr_cnt
  );

  modport slave (
    input  run_sw, step_btn, bflag_raw, pc_value, wait_req, halt_req, bkpt_addr, bkpt_on,
    output cpu_en, state_o, halted, bkpt_hit, instr_cnt
  );
endinterface

// File: rtl/pico_exec_ctrl.sv
// Execution sequencer for the 8-bit picoMIPS: run/step/halt/wait-for-Bflag commit control.
// Breakpoint compare is compiled in only when PICO_BKPT_EN is defined.
module pico_exec_ctrl #(
  parameter int unsigned Psize = 6,
  parameter int unsigned CNTW  = 16
) (
  input logic              clk,
  input logic              reset,
  pico_exec_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StStep    = 3'd2,
    StWaitIn  = 3'd3,
    StWaitRel = 3'd4,
    StHalt    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            step_s1_q, step_s2_q, step_dly_q;
  logic            bflag_s1_q, bflag_s2_q;
  logic            step_rise;
  logic            bkpt_match;
  logic            cpu_en;
  logic            bkpt_hit;
  logic [Psize-1:0] pc_w;

  assign pc_w = bus.pc_value;

`ifdef PICO_BKPT_EN
  assign bkpt_match = bus.bkpt_on && (pc_w == bus.bkpt_addr);
`else
  logic [Psize-1:0] unused_pc;
  logic             unused_on;
  assign unused_pc  = pc_w ^ bus.bkpt_addr;
  assign unused_on  = bus.bkpt_on;
  assign bkpt_match = 1'b0;
`endif

  assign step_rise = step_s2_q & ~step_dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      step_s1_q  <= 1'b0;
      step_s2_q  <= 1'b0;
      step_dly_q <= 1'b0;
      bflag_s1_q <= 1'b0;
      bflag_s2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_s1_q  <= bus.step_btn;
      step_s2_q  <= step_s1_q;
      step_dly_q <= step_s2_q;
      bflag_s1_q <= bus.bflag_raw;
      bflag_s2_q <= bflag_s1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cpu_en   = 1'b0;
    bkpt_hit = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.run_sw)     state_d = StRun;
        else if (step_rise) state_d = StStep;
      end
      StRun: begin
        // halt outranks a breakpoint on the same instruction, so no hit pulse then
        if (bus.halt_req) begin
          state_d = StHalt;
        end else if (bkpt_match) begin
          state_d  = StIdle;
          bkpt_hit = 1'b1;
        end else if (bus.wait_req) begin
          state_d = StWaitIn;
        end else if (!bus.run_sw) begin
          state_d = StIdle;
        end else begin
          cpu_en = 1'b1;
        end
      end
      StStep: begin
        if (bus.halt_req) begin
          state_d = StHalt;
        end else if (bus.wait_req) begin
          state_d = StWaitIn;
        end else begin
          cpu_en  = 1'b1;
          state_d = StIdle;
        end
      end
      StWaitIn: begin
        // commit in the Bflag cycle so the input read sees the flag asserted
        if (bflag_s2_q) begin
          cpu_en  = 1'b1;
          state_d = StWaitRel;
        end
      end
      StWaitRel: begin
        if (!bflag_s2_q) state_d = bus.run_sw ? StRun : StIdle;
      end
      StHalt: begin
        if (!bus.run_sw) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cpu_en && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  assign bus.cpu_en    = cpu_en;
  assign bus.bkpt_hit  = bkpt_hit;
  assign bus.state_o   = state_q;
  assign bus.halted    = (state_q == StHalt);
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_pico_exec_ctrl.sv
// Directed bench for pico_exec_ctrl: reset, free run, step, Bflag handshake, breakpoint,
// halt, and counter saturation on a narrow-counter second instance.
module tb_pico_exec_ctrl;
  localparam int unsigned Psize = 6;
  localparam int unsigned CNTW  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pico_exec_ctrl_if #(.Psize(Psize), .CNTW(CNTW)) bus ();
  pico_exec_ctrl_if #(.Psize(Psize), .CNTW(4))    sbus ();

  pico_exec_ctrl #(.Psize(Psize), .CNTW(CNTW)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  pico_exec_ctrl #(.Psize(Psize), .CNTW(4))    u_sat (.clk(clk), .reset(reset), .bus(sbus));

  // Minimal PC block: advances on every commit.
  logic [Psize-1:0] pc_q;
  logic             wait_en;
  logic             halt_en;

  always @(posedge clk or posedge reset) begin
    if (reset)           pc_q <= '0;
    else if (bus.cpu_en) pc_q <= pc_q + 1'b1;
  end

  assign bus.pc_value  = pc_q;
  assign bus.wait_req  = wait_en && (pc_q == 6'd4);
  assign bus.halt_req  = halt_en;
  assign sbus.pc_value = '0;
  assign sbus.wait_req = 1'b0;
  assign sbus.halt_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int commits;
    int pos;
    bit found;
    int hits;
    int exp_cnt;

    bus.run_sw     = 1'b0;
    bus.step_btn   = 1'b0;
    bus.bflag_raw  = 1'b0;
    bus.bkpt_addr  = 6'd7;
    bus.bkpt_on    = 1'b0;
    wait_en        = 1'b0;
    halt_en        = 1'b0;
    sbus.run_sw    = 1'b0;
    sbus.step_btn  = 1'b0;
    sbus.bflag_raw = 1'b0;
    sbus.bkpt_addr = '0;
    sbus.bkpt_on   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_state", bus.state_o, 0);
    check("rst_cpu_en", bus.cpu_en, 0);
    check("rst_cnt", bus.instr_cnt, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_bkpt_hit", bus.bkpt_hit, 0);
    reset = 1'b0;

    // Free run: 10 commits
    @(negedge clk);
    bus.run_sw = 1'b1;
    #1;
    check("idle_no_commit", bus.cpu_en, 0);
    @(negedge clk);
    check("run_entry", bus.state_o, 1);
    commits = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cpu_en && bus.state_o == 3'd1) commits++;
      @(negedge clk);
    end
    bus.run_sw = 1'b0;
    #1;
    check("run_commits", commits, 10);
    check("run_cnt10", bus.instr_cnt, 10);
    check("run_stop_cpu_en", bus.cpu_en, 0);
    @(negedge clk);
    check("run_to_idle", bus.state_o, 0);

    // Bring the count to 37, then reset mid-RUN
    bus.run_sw = 1'b1;
    @(negedge clk);
    repeat (27) @(negedge clk);
    check("cnt37", bus.instr_cnt, 37);
    #2 reset = 1'b1;
    #1;
    check("midrun_rst_state", bus.state_o, 0);
    check("midrun_rst_cpu_en", bus.cpu_en, 0);
    check("midrun_rst_cnt", bus.instr_cnt, 0);
    bus.run_sw = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    commits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cpu_en) commits++;
    end
    check("post_rst_idle", commits, 0);

    // Single step: held button gives one commit, 3-4 cycles after the raw edge
    bus.step_btn = 1'b1;
    commits = 0;
    pos = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.cpu_en) begin
        commits++;
        if (pos < 0) pos = i;
      end
    end
    bus.step_btn = 1'b0;
    check("step_one_commit", commits, 1);
    check("step_latency", (pos >= 3 && pos <= 4), 1);
    repeat (4) @(negedge clk);
    check("step_cnt", bus.instr_cnt, 1);
    check("step_idle", bus.state_o, 0);

    // Bflag handshake at pc=4
    wait_en    = 1'b1;
    bus.run_sw = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.state_o == 3'd3) found = 1'b1;
    end
    check("wait_in_reached", found, 1);
    check("wait_pc", pc_q, 4);
    check("wait_cnt", bus.instr_cnt, 4);
    commits = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.cpu_en) commits++;
      @(negedge clk);
    end
    check("wait_no_commit", commits, 0);
    bus.bflag_raw = 1'b1;
    commits = 0;
    pos = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.cpu_en) begin
        commits++;
        if (pos < 0) pos = i;
      end
    end
    check("bflag_one_commit", commits, 1);
    check("bflag_latency", (pos >= 2 && pos <= 3), 1);
    check("wait_rel_state", bus.state_o, 4);
    bus.bflag_raw = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.state_o == 3'd1) found = 1'b1;
    end
    check("run_resume", found, 1);
    check("resume_commit", bus.cpu_en, 1);
    bus.run_sw = 1'b0;
    wait_en    = 1'b0;
    #1;
    check("resume_stop", bus.cpu_en, 0);
    check("bflag_cnt", bus.instr_cnt, 5);
    @(negedge clk);

    // Breakpoint at pc=7, starting from pc=5
    bus.bkpt_on   = 1'b1;
    bus.bkpt_addr = 6'd7;
    bus.run_sw    = 1'b1;
`ifdef PICO_BKPT_EN
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.bkpt_hit) found = 1'b1;
    end
    check("bkpt_hit_seen", found, 1);
    check("bkpt_pc", pc_q, 7);
    check("bkpt_no_commit", bus.cpu_en, 0);
    @(negedge clk);
    check("bkpt_idle", bus.state_o, 0);
    check("bkpt_pulse_end", bus.bkpt_hit, 0);
    bus.run_sw   = 1'b0;
    bus.step_btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.cpu_en) found = 1'b1;
    end
    check("bkpt_step_commit", found, 1);
    check("bkpt_step_pc", pc_q, 7);
    bus.step_btn = 1'b0;
    repeat (4) @(negedge clk);
    check("bkpt_step_adv", pc_q, 8);
    exp_cnt = 8;
`else
    hits  = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.bkpt_hit) hits++;
      if (pc_q == 6'd9) found = 1'b1;
    end
    bus.run_sw = 1'b0;
    check("nobkpt_passes", found, 1);
    check("nobkpt_hits", hits, 0);
    exp_cnt = 9;
    repeat (2) @(negedge clk);
`endif
    bus.bkpt_on = 1'b0;
    check("pre_halt_cnt", bus.instr_cnt, exp_cnt);

    // Halt: sticks, ignores step
    halt_en    = 1'b1;
    bus.run_sw = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.halted) found = 1'b1;
    end
    check("halt_reached", found, 1);
    check("halt_state", bus.state_o, 5);
    check("halt_cpu_en", bus.cpu_en, 0);
    bus.step_btn = 1'b1;
    repeat (10) @(negedge clk);
    bus.step_btn = 1'b0;
    repeat (5) @(negedge clk);
    check("halt_sticky", bus.halted, 1);
    check("halt_cnt", bus.instr_cnt, exp_cnt);
    bus.run_sw = 1'b0;
    @(negedge clk);
    check("halt_exit", bus.state_o, 0);
    check("halt_exit_flag", bus.halted, 0);
    halt_en = 1'b0;

    // Saturation on the 4-bit counter instance
    sbus.run_sw = 1'b1;
    @(negedge clk);
    commits = 0;
    for (int i = 0; i < 20; i++) begin
      if (sbus.cpu_en) commits++;
      @(negedge clk);
    end
    check("sat_commits", commits, 20);
    check("sat_cnt", sbus.instr_cnt, 15);
    repeat (5) @(negedge clk);
    check("sat_hold", sbus.instr_cnt, 15);
    sbus.run_sw = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
